// File: rtl/sys_array_pkg.sv
// Shared types and defaults for the systolic-array result drain.
package sys_array_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/sys_array_skid2.sv
// Two-entry valid/ready buffer. The producer must only push while fewer than two entries are held.
module sys_array_skid2 #(
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_in_valid,
  input  logic [DW-1:0] i_in_data,
  output logic          o_out_valid,
  output logic [DW-1:0] o_out_data,
  input  logic          i_out_ready,
  output logic [1:0]    o_count
);

  logic [DW-1:0] r_mem [2];
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = (r_count != 2'd0) && i_out_ready;
  assign w_push = i_in_valid && (r_count != 2'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_in_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_out_valid = (r_count != 2'd0);
  assign o_out_data  = r_mem[r_rd_ptr];
  assign o_count     = r_count;

endmodule

// File: rtl/sys_array_result_drain.sv
// Drains the two column-result FIFOs in lockstep into packed {col1, col0} rows on a
// valid/ready stream, counting rows against a programmed total.
module sys_array_result_drain
  import sys_array_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_rows,
  input  logic [WIDTH-1:0]   col0_out_data,
  input  logic               col0_read_ready,
  output logic               col0_read_valid,
  input  logic [WIDTH-1:0]   col1_out_data,
  input  logic               col1_read_ready,
  output logic               col1_read_valid,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  drain_state_e     r_state;
  drain_state_e     w_state_next;
  logic [CNT_W-1:0] r_rows;
  logic [CNT_W-1:0] r_popped;
  logic             w_load;
  logic             w_pop;
  logic [1:0]       w_count;

  // Pop depends only on registered state and FIFO flags, never on out_ready.
  assign w_pop = (r_state == StDrain) && col0_read_ready && col1_read_ready &&
                 (r_popped < r_rows) && (w_count < 2'd2);

  assign col0_read_valid = w_pop;
  assign col1_read_valid = w_pop;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = (num_rows == '0) ? StDone : StDrain;
        end
      end
      StDrain: begin
        // Finish as the last buffered row is accepted so done rises the following cycle.
        if ((r_popped == r_rows) &&
            ((w_count == 2'd0) || ((w_count == 2'd1) && out_ready))) begin
          w_state_next = StDone;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_rows   <= '0;
      r_popped <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_rows   <= num_rows;
        r_popped <= '0;
      end else if (w_pop) begin
        r_popped <= r_popped + 1'b1;
      end
    end
  end

  sys_array_skid2 #(
    .DW (2 * WIDTH)
  ) u_skid (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_in_valid  (w_pop),
    .i_in_data   ({col1_out_data, col0_out_data}),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .i_out_ready (out_ready),
    .o_count     (w_count)
  );

  assign busy = (r_state == StDrain);
  assign done = (r_state == StDone);

endmodule

// File: tb/tb_sys_array_result_drain.sv
// Randomised bench for sys_array_result_drain with queue-based FIFO and row-stream model.
module tb_sys_array_result_drain;

  localparam int unsigned W = 16;
  localparam int unsigned C = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [C-1:0]   num_rows;
  logic [W-1:0]   col0_out_data;
  logic           col0_read_ready;
  logic           col0_read_valid;
  logic [W-1:0]   col1_out_data;
  logic           col1_read_ready;
  logic           col1_read_valid;
  logic [2*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic           done;

  sys_array_result_drain #(
    .WIDTH (W),
    .CNT_W (C)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_rows        (num_rows),
    .col0_out_data   (col0_out_data),
    .col0_read_ready (col0_read_ready),
    .col0_read_valid (col0_read_valid),
    .col1_out_data   (col1_out_data),
    .col1_read_ready (col1_read_ready),
    .col1_read_valid (col1_read_valid),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Push/flush requests from the stimulus, applied by the model process.
  logic         push0_req = 1'b0;
  logic         push1_req = 1'b0;
  logic [W-1:0] push0_val = '0;
  logic [W-1:0] push1_val = '0;
  logic         flush_req = 1'b0;

  // Observations collected by the model process.
  logic [31:0] acc_log[$];
  int          acc_cyc[$];
  int          n_pops      = 0;
  int          n_done_rise = 0;
  int          done_cyc    = 0;
  int          cyc         = 0;

  logic [W-1:0]   q0[$];
  logic [W-1:0]   q1[$];
  logic [2*W-1:0] m_buf[$];
  int             m_rows   = 0;
  int             m_popped = 0;
  bit             m_drain  = 1'b0;
  bit             m_done   = 1'b0;

  task automatic refresh_fifo();
    col0_read_ready = (q0.size() != 0);
    col1_read_ready = (q1.size() != 0);
    col0_out_data   = (q0.size() != 0) ? q0[0] : '0;
    col1_out_data   = (q1.size() != 0) ? q1[0] : '0;
  endtask

  initial begin : model
    bit exp_pop, acc, st, prev_done;
    int st_rows;
    prev_done = 1'b0;
    refresh_fifo();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        m_buf.delete();
        m_drain  = 1'b0;
        m_done   = 1'b0;
        m_rows   = 0;
        m_popped = 0;
        exp_pop  = 1'b0;
        acc      = 1'b0;
        st       = 1'b0;
      end else begin
        exp_pop = m_drain && (q0.size() > 0) && (q1.size() > 0) &&
                  (m_popped < m_rows) && (m_buf.size() < 2);
        acc     = (m_buf.size() > 0) && out_ready;
        st      = start && !m_drain;
      end
      st_rows = int'(num_rows);
      check("col0_read_valid", {31'd0, col0_read_valid}, {31'd0, exp_pop});
      check("col1_read_valid", {31'd0, col1_read_valid}, {31'd0, exp_pop});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_buf.size() > 0});
      if (m_buf.size() > 0) check("out_data", out_data, m_buf[0]);
      else if (!rst) check("out_data_rst", out_data, 32'd0);
      check("busy", {31'd0, busy}, {31'd0, m_drain});
      check("done", {31'd0, done}, {31'd0, m_done});
      if (rst && col0_read_valid) n_pops++;
      if (acc) begin
        acc_log.push_back(out_data);
        acc_cyc.push_back(cyc);
      end
      if (done && !prev_done) begin
        n_done_rise++;
        done_cyc = cyc;
      end
      prev_done = done;

      @(posedge clk);
      #1;
      if (rst) begin
        if (acc) void'(m_buf.pop_front());
        if (exp_pop) begin
          m_buf.push_back({q1[0], q0[0]});
          void'(q0.pop_front());
          void'(q1.pop_front());
          m_popped++;
        end
        if (st) begin
          m_rows   = st_rows;
          m_popped = 0;
          m_drain  = (st_rows != 0);
          m_done   = (st_rows == 0);
        end else if (m_drain && (m_popped == m_rows) && (m_buf.size() == 0)) begin
          m_drain = 1'b0;
          m_done  = 1'b1;
        end
      end
      if (flush_req) begin
        q0.delete();
        q1.delete();
      end
      if (push0_req) q0.push_back(push0_val);
      if (push1_req) q1.push_back(push1_val);
      refresh_fifo();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_row(input logic [W-1:0] c0, input logic [W-1:0] c1);
    push0_req = 1'b1; push0_val = c0;
    push1_req = 1'b1; push1_val = c1;
    tick();
    push0_req = 1'b0;
    push1_req = 1'b0;
  endtask

  task automatic push_col1(input logic [W-1:0] c1);
    push1_req = 1'b1; push1_val = c1;
    tick();
    push1_req = 1'b0;
  endtask

  task automatic do_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic do_start(input int n);
    start    = 1'b1;
    num_rows = C'(n);
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done) check(nm, 32'd0, 32'd1);
    tick();
  endtask

  task automatic check_rows(input string nm, input int base, input logic [31:0] exp[$]);
    check({nm, "_count"}, acc_log.size() - base, exp.size());
    if (acc_log.size() - base == exp.size()) begin
      foreach (exp[i]) check(nm, acc_log[base + i], exp[i]);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int b, p, r;
    logic [31:0] exp[$];
    rst = 1'b0; start = 1'b0; num_rows = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    rst = 1'b1;
    tick();

    // Basic three-row drain.
    push_row(16'd1, 16'd10);
    push_row(16'd2, 16'd20);
    push_row(16'd3, 16'd30);
    b = acc_log.size();
    do_start(3);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done("t1_done_timeout", 50);
    exp = '{32'h000A0001, 32'h00140002, 32'h001E0003};
    check_rows("t1_rows", b, exp);
    if (acc_cyc.size() == b + 3) begin
      check("t1_consecutive", acc_cyc[b + 2] - acc_cyc[b], 32'd2);
      check("t1_done_latency", done_cyc - acc_cyc[b + 2], 32'd1);
    end

    // col1 arrives late: nothing pops until both columns have data.
    b = acc_log.size();
    push0_req = 1'b1; push0_val = 16'd11; tick();
    push0_val = 16'd12; tick();
    push0_req = 1'b0;
    p = n_pops;
    do_start(2);
    repeat (4) tick();
    check("t2_no_pop", n_pops - p, 32'd0);
    push_col1(16'd21);
    push_col1(16'd22);
    wait_done("t2_done_timeout", 50);
    exp = '{32'h0015000B, 32'h0016000C};
    check_rows("t2_rows", b, exp);

    // Backpressure: buffer fills at two rows, then drains in order.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_row(W'(16'h100 + i), W'(16'h200 + i));
    b = acc_log.size();
    p = n_pops;
    do_start(4);
    repeat (5) tick();
    check("t3_pops_full", n_pops - p, 32'd2);
    check("t3_valid_held", {31'd0, out_valid}, 32'd1);
    check("t3_data_held", out_data, 32'h02000100);
    out_ready = 1'b1;
    wait_done("t3_done_timeout", 50);
    exp = '{32'h02000100, 32'h02010101, 32'h02020102, 32'h02030103};
    check_rows("t3_rows", b, exp);

    // Zero rows: immediate done, no pops even with data present.
    push_row(16'h55, 16'h66);
    p = n_pops;
    do_start(0);
    check("t4_done_next", {31'd0, done}, 32'd1);
    repeat (3) tick();
    check("t4_no_pop", n_pops - p, 32'd0);
    do_flush();

    // Reset after the first accepted row of three.
    push_row(16'h31, 16'h41);
    push_row(16'h32, 16'h42);
    push_row(16'h33, 16'h43);
    b = acc_log.size();
    do_start(3);
    r = 0;
    while (acc_log.size() == b && r < 20) begin
      @(negedge clk);
      r++;
    end
    check("t5_first_row", acc_log.size() - b, 32'd1);
    tick();
    rst = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_data", out_data, 32'd0);
    check("t5_rst_flags", {28'd0, busy, done, col0_read_valid, col1_read_valid}, 32'd0);
    tick();
    rst = 1'b1;
    do_flush();
    push_row(16'h71, 16'h81);
    push_row(16'h72, 16'h82);
    b = acc_log.size();
    do_start(2);
    wait_done("t5_done_timeout", 50);
    exp = '{32'h00810071, 32'h00820072};
    check_rows("t5_rows", b, exp);

    // A second start during a drain is ignored.
    out_ready = 1'b0;
    push_row(16'hA1, 16'hB1);
    push_row(16'hA2, 16'hB2);
    push_row(16'hA3, 16'hB3);
    push_row(16'hA4, 16'hB4);
    b = acc_log.size();
    p = n_done_rise;
    do_start(3);
    tick();
    do_start(7);
    out_ready = 1'b1;
    wait_done("t6_done_timeout", 50);
    repeat (4) tick();
    exp = '{32'h00B100A1, 32'h00B200A2, 32'h00B300A3};
    check_rows("t6_rows", b, exp);
    check("t6_done_once", n_done_rise - p, 32'd1);
    check("t6_done_held", {31'd0, done}, 32'd1);
    do_flush();

    // Randomised drains: independent column arrival and random backpressure.
    for (int it = 0; it < 8; it++) begin
      logic [W-1:0] d0[$];
      logic [W-1:0] d1[$];
      int n;
      n = int'($urandom_range(1, 6));
      exp.delete();
      for (int i = 0; i < n; i++) begin
        d0.push_back(W'($urandom));
        d1.push_back(W'($urandom));
        exp.push_back({d1[i], d0[i]});
      end
      b = acc_log.size();
      do_start(n);
      fork
        begin
          for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            push0_req = 1'b1; push0_val = d0[i]; tick(); push0_req = 1'b0;
          end
        end
        begin
          for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            push1_req = 1'b1; push1_val = d1[i]; tick(); push1_req = 1'b0;
          end
        end
        begin
          for (int k = 0; k < 400 && !done; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
          end
          out_ready = 1'b1;
        end
      join
      wait_done("rand_done_timeout", 20);
      check_rows("rand_rows", b, exp);
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_array_result_drain.md
# sys_array_result_drain

Downstream stage of `sys_array_2x2`: drains the two column-result FIFOs (the FIFOs the array writes through its `fifo_4_*`/`fifo_5_*` ports) in lockstep. Pairs one word from each column into a packed row word and emits it on a valid/ready stream. Counts rows against a programmed total and raises `done` once every row has been delivered downstream.

## Interface
Parameters:
- `WIDTH`, 16, width of one column result
- `CNT_W`, 8, width of row counter / `num_rows`

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `start`  in  1  one-cycle pulse; latches `num_rows`, begins a drain
- `num_rows`  in  CNT_W  rows to drain, sampled only on accepted `start`
- `col0_out_data`  in  WIDTH  head word of column-0 FIFO (first-word-fall-through)
- `col0_read_ready`  in  1  column-0 FIFO non-empty
- `col0_read_valid`  out  1  pop request to column-0 FIFO
- `col1_out_data`, `col1_read_ready`, `col1_read_valid`: same, column 1
- `out_data`  out  2*WIDTH  packed row {col1, col0}
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  downstream accepts
- `busy`  out  1  state is DRAIN
- `done`  out  1  last drain complete

## Operation
- States: IDLE, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE + `start`: latch `num_rows`, clear `popped`; go to DRAIN, or straight to DONE if `num_rows`=0. `start` in DRAIN is ignored.
- Pop rule (DRAIN only): assert both `col0_read_valid` and `col1_read_valid` in the same cycle iff `col0_read_ready` && `col1_read_ready` && `popped` < latched rows && buffer count < 2. Never pop one column alone.
- Pop writes {`col1_out_data`, `col0_out_data`} into the 2-entry output buffer and increments `popped`.
- `out_valid` = buffer count > 0; `out_data` = buffer head. An entry leaves when `out_valid` && `out_ready`.
- DRAIN → DONE when `popped` == latched rows and the buffer is empty.
- DONE holds `done`=1 until the next accepted `start`.
- Pop condition is a function of registered state and FIFO flags only. There is no combinational path from `out_ready` to `*_read_valid`.

## Timing
- Reset values: `col*_read_valid`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0; buffer count 0, `popped` 0.
- `start` at edge T → `busy`=1 after T; the first pop is possible in the cycle after T.
- Pop latency: FIFO words present and pop at edge P → `out_valid`=1 in the cycle after P.
- Throughput: 1 row/cycle when both FIFOs stay non-empty and `out_ready`=1. Buffer count holds at 1.
- Push and pop of the buffer in the same cycle: count unchanged, order preserved.
- Buffer full (count 2): no FIFO pop until an entry drains.
- `out_ready`=0 with `out_valid`=1: `out_data` holds stable.
- Only one column non-empty: no pop; that column's word waits.
- `done` rises the cycle after the last buffer entry is accepted.
- `popped` saturates at the latched count and never wraps.
- Reset mid-drain: all state clears immediately, buffered rows are discarded, and FIFO contents are untouched.

## Structure
- `sys_array_pkg`: state enum (IDLE/DRAIN/DONE), default `WIDTH`, `CNT_W`.
- Sub-module `sys_array_skid2`: 2-entry valid/ready buffer, parameterised on data width, async active-low reset.
- The FSM, row counter and pop logic live in the top module.

## Test plan
- Reset, then `start` with `num_rows`=3. Both FIFOs preloaded with col0 {1,2,3} and col1 {10,20,30}, `out_ready`=1 → outputs 0x000A0001, 0x00140002, 0x001E0003 on consecutive cycles; `done`=1 one cycle after the last.
- Col0 holds 2 words, col1 is empty; col1's words arrive 4 cycles later → no pop while col1 is empty; both rows emitted correctly paired.
- `out_ready`=0 for 5 cycles with both FIFOs full, `num_rows`=4 → exactly 2 pops, `out_valid` stays high, data stable; releasing `out_ready` drains all 4 rows in order.
- `start` with `num_rows`=0 → `done`=1 next cycle and no `read_valid` ever asserted.
- Assert `rst`=0 mid-drain after 1 of 3 rows → all outputs at reset values. Then `start` with `num_rows`=2 drains 2 fresh rows.
- A second `start` pulse during DRAIN → ignored; the original row count completes and `done` asserts once.
